// File: rtl/cpu_ctrl_fsm.sv
// cpu_ctrl_fsm: Moore control sequencer for the simple RISC datapath.
// Fetch (IF1/IF2), PC update, decode, then a short execute sequence per
// instruction class. All strobes decode from the state and the live IR.
// Optional feature: define MEM_LDST_EN to decode LDR (011_00) and STR (100_00);
// otherwise those encodings halt with illegal set.
module cpu_ctrl_fsm #(
  parameter int MEM_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] ir,
  output logic        load_ir,
  output logic        load_pc,
  output logic        pc_sel,
  output logic        addr_sel,
  output logic        load_addr,
  output logic [1:0]  mem_cmd,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic [1:0]  vsel,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic        bsel,
  output logic        shift_en,
  output logic        halted,
  output logic        illegal
);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPD, S_DEC, S_WIMM, S_GA, S_GB, S_ALU, S_CMP,
    S_WB, S_HALT, S_ADR, S_LA, S_MRD, S_LDWB, S_GBD, S_PASS, S_MWR
  } state_t;

  state_t     state, state_n;
  logic [3:0] wait_cnt;
  logic       wait_done;
  logic       counting;

  // IR fields; ir[4:3] is the shift amount consumed by the datapath shifter.
  logic [4:0] key;
  logic [2:0] rn, rd, rm;
  logic       unused_shift;
  assign key          = ir[15:11];
  assign rn           = ir[10:8];
  assign rd           = ir[7:5];
  assign rm           = ir[2:0];
  assign unused_shift = ^ir[4:3];

  logic is_movi, is_movr, is_add, is_and, is_cmp, is_mvn, is_halt, legal;
  assign is_movi = (key == 5'b11010);
  assign is_movr = (key == 5'b11000);
  assign is_add  = (key == 5'b10100);
  assign is_and  = (key == 5'b10110);
  assign is_cmp  = (key == 5'b10101);
  assign is_mvn  = (key == 5'b10111);
  assign is_halt = (ir[15:13] == 3'b111);

`ifdef MEM_LDST_EN
  logic is_ldr, is_str;
  assign is_ldr = (key == 5'b01100);
  assign is_str = (key == 5'b10000);
  assign legal  = is_movi | is_movr | is_add | is_and | is_cmp | is_mvn |
                  is_halt | is_ldr | is_str;
`else
  assign legal  = is_movi | is_movr | is_add | is_and | is_cmp | is_mvn |
                  is_halt;
`endif

  // Memory reads stay in their state for MEM_WAIT cycles in total.
  assign counting  = (state == S_IF1) || (state == S_MRD);
  assign wait_done = (wait_cnt == 4'(MEM_WAIT - 1));

  // State register, wait counter and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RST;
      wait_cnt <= '0;
      illegal  <= 1'b0;
    end else begin
      state    <= state_n;
      wait_cnt <= (counting && !wait_done) ? wait_cnt + 4'd1 : 4'd0;
      if (state == S_DEC && !legal) illegal <= 1'b1;
    end
  end

  // Next-state sequencing.
  always_comb begin
    state_n = state;
    case (state)
      S_RST:  state_n = S_IF1;
      S_IF1:  state_n = wait_done ? S_IF2 : S_IF1;
      S_IF2:  state_n = S_UPD;
      S_UPD:  state_n = S_DEC;
      S_DEC: begin
        if (is_movi)                     state_n = S_WIMM;
        else if (is_movr || is_mvn)      state_n = S_GB;
        else if (is_add || is_and || is_cmp) state_n = S_GA;
`ifdef MEM_LDST_EN
        else if (is_ldr || is_str)       state_n = S_GA;
`endif
        else                             state_n = S_HALT;
      end
      S_WIMM: state_n = S_IF1;
`ifdef MEM_LDST_EN
      S_GA:   state_n = (is_ldr || is_str) ? S_ADR : S_GB;
      S_ADR:  state_n = S_LA;
      S_LA:   state_n = is_ldr ? S_MRD : S_GBD;
      S_MRD:  state_n = wait_done ? S_LDWB : S_MRD;
      S_LDWB: state_n = S_IF1;
      S_GBD:  state_n = S_PASS;
      S_PASS: state_n = S_MWR;
      S_MWR:  state_n = S_IF1;
`else
      S_GA:   state_n = S_GB;
`endif
      S_GB:   state_n = is_cmp ? S_CMP : S_ALU;
      S_ALU:  state_n = S_WB;
      S_CMP:  state_n = S_IF1;
      S_WB:   state_n = S_IF1;
      S_HALT: state_n = S_HALT;
      default: state_n = S_HALT;
    endcase
  end

  // Moore strobe decode; anything not named for a state stays 0.
  always_comb begin
    load_ir   = 1'b0;
    load_pc   = 1'b0;
    pc_sel    = 1'b0;
    addr_sel  = 1'b0;
    load_addr = 1'b0;
    mem_cmd   = 2'b00;
    readnum   = 3'd0;
    writenum  = 3'd0;
    write     = 1'b0;
    vsel      = 2'b00;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    shift_en  = 1'b0;
    halted    = 1'b0;
    case (state)
      S_RST:  load_pc = 1'b1;
      S_IF1:  begin addr_sel = 1'b1; mem_cmd = 2'b01; end
      S_IF2:  begin addr_sel = 1'b1; mem_cmd = 2'b01; load_ir = 1'b1; end
      S_UPD:  begin load_pc = 1'b1; pc_sel = 1'b1; end
      S_WIMM: begin writenum = rn; vsel = 2'b01; write = 1'b1; end
      S_GA:   begin readnum = rn; loada = 1'b1; end
      S_GB:   begin readnum = rm; loadb = 1'b1; end
      // MOV reg passes B through by zeroing the A operand.
      S_ALU:  begin shift_en = 1'b1; loadc = 1'b1; asel = is_movr; end
      S_CMP:  begin shift_en = 1'b1; loads = 1'b1; end
      S_WB:   begin writenum = rd; vsel = 2'b00; write = 1'b1; end
      S_HALT: halted = 1'b1;
`ifdef MEM_LDST_EN
      S_ADR:  begin bsel = 1'b1; loadc = 1'b1; end
      S_LA:   load_addr = 1'b1;
      S_MRD:  mem_cmd = 2'b01;
      S_LDWB: begin writenum = rd; vsel = 2'b11; write = 1'b1; end
      S_GBD:  begin readnum = rd; loadb = 1'b1; end
      S_PASS: begin asel = 1'b1; loadc = 1'b1; end
      S_MWR:  mem_cmd = 2'b10;
`endif
      default: ;
    endcase
  end

endmodule
